// File: rtl/aes_sub_shift.sv
// AES SubBytes + ShiftRows stage: iterates over the 16 state bytes SBOXES at a time
// through shared forward S-boxes, then applies ShiftRows and pulses done_o for MixColumns.
module aes_sub_shift #(
  parameter int SBOXES = 4
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [127:0] state_i,
  input  logic         last_round_i,
  output logic [127:0] state_o,
  output logic         done_o,
  output logic         last_round_o,
  output logic         busy_o
);

  localparam int N  = 16 / SBOXES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SUB} fsm_t;

  // FIPS-197 forward S-box, row = high nibble, column = low nibble.
  localparam logic [7:0] SBOX_TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  // Row r rotates left by r columns: out[r][c] = in[r][(c+r) mod 4].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
      end
    end
    return res;
  endfunction

  fsm_t          fsm_q, fsm_d;
  logic [CW-1:0] cnt_q;
  logic [127:0]  in_buf_q;
  logic [127:0]  sub_buf_q;
  logic          lr_q;
  logic [127:0]  merged;
  logic          last_grp;

  assign last_grp = (cnt_q == CW'(N - 1));
  assign busy_o   = (fsm_q != IDLE);

  // NOTE: every combinational output gets a default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (en_i) fsm_d = SUB;
      SUB:     if (last_grp) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Current byte group substituted into the partially built result; the S-box
  // lookups in this loop are the SBOXES shared instances.
  always_comb begin
    merged = sub_buf_q;
    for (int j = 0; j < SBOXES; j++) begin
      merged[127 - 8*(int'(cnt_q)*SBOXES + j) -: 8] =
        sbox(in_buf_q[127 - 8*(int'(cnt_q)*SBOXES + j) -: 8]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // NOTE: the block buffers are plain registers, not RAM, so they are cleared by reset
  // along with the control state; a reset mid-block leaves no stale data behind.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      in_buf_q     <= '0;
      sub_buf_q    <= '0;
      lr_q         <= 1'b0;
      state_o      <= '0;
      done_o       <= 1'b0;
      last_round_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (en_i) begin
            in_buf_q <= state_i;
            lr_q     <= last_round_i;
            cnt_q    <= '0;
          end
        end
        SUB: begin
          sub_buf_q <= merged;
          if (last_grp) begin
            state_o      <= shift_rows(merged);
            last_round_o <= lr_q;
            done_o       <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sub_shift.sv
// Directed bench for aes_sub_shift: FIPS-197 vectors, busy collision, resets,
// and SBOXES = 4/8/16 latency comparison on shared stimulus.
module tb_aes_sub_shift;

  localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] APPB_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  logic         clk_i = 1'b0;
  logic         rst_n = 1'b1;
  logic         en_i = 1'b0;
  logic [127:0] state_i = '0;
  logic         last_round_i = 1'b0;

  logic [127:0] state4, state8, state16;
  logic         done4, done8, done16;
  logic         lr4, lr8, lr16;
  logic         busy4, busy8, busy16;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk_i = ~clk_i;

  aes_sub_shift #(.SBOXES(4)) dut4 (
    .clk_i(clk_i), .rst_n(rst_n), .en_i(en_i), .state_i(state_i), .last_round_i(last_round_i),
    .state_o(state4), .done_o(done4), .last_round_o(lr4), .busy_o(busy4));
  aes_sub_shift #(.SBOXES(8)) dut8 (
    .clk_i(clk_i), .rst_n(rst_n), .en_i(en_i), .state_i(state_i), .last_round_i(last_round_i),
    .state_o(state8), .done_o(done8), .last_round_o(lr8), .busy_o(busy8));
  aes_sub_shift #(.SBOXES(16)) dut16 (
    .clk_i(clk_i), .rst_n(rst_n), .en_i(en_i), .state_i(state_i), .last_round_i(last_round_i),
    .state_o(state16), .done_o(done16), .last_round_o(lr16), .busy_o(busy16));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives a one-cycle start pulse; on return the accepting edge has just passed.
  task automatic start(input logic [127:0] s, input logic lr);
    en_i = 1'b1;
    state_i = s;
    last_round_i = lr;
    tick();
    en_i = 1'b0;
  endtask

  task automatic wait_done4(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done4) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [15:0] done_seq;
    int lat8, lat16, bsy4, bsy8, bsy16;
    logic [127:0] res8, res16;

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_state", state4, '0);
    check("rst_async_flags", {done4, lr4, busy4}, 3'b000);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_state", state4, '0);
      check("idle_flags", {done4, lr4, busy4}, 3'b000);
    end

    // FIPS-197 Appendix B round 1.
    start(APPB_IN, 1'b0);
    check("appb_busy", busy4, 1'b1);
    wait_done4(lat);
    check("appb_latency", lat, 4);
    check("appb_state", state4, APPB_OUT);
    check("appb_lr", lr4, 1'b0);
    check("appb_busy_at_done", busy4, 1'b0);
    tick();
    check("appb_done_fall", done4, 1'b0);
    check("appb_hold", state4, APPB_OUT);

    // Uniform blocks and last-round flag.
    start('0, 1'b1);
    wait_done4(lat);
    check("zero_latency", lat, 4);
    check("zero_state", state4, {16{8'h63}});
    check("zero_lr", lr4, 1'b1);
    tick();
    start({16{8'h53}}, 1'b0);
    wait_done4(lat);
    check("x53_state", state4, {16{8'hed}});
    check("x53_lr", lr4, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    // en_i held high for 12 edges; input changes after the first acceptance.
    en_i = 1'b1;
    state_i = APPB_IN;
    last_round_i = 1'b0;
    tick();
    state_i = {16{8'hff}};
    done_seq = '0;
    for (int i = 0; i < 16; i++) begin
      done_seq[i] = done4;
      if (i == 4) check("coll_first_state", state4, APPB_OUT);
      if (i == 9) check("coll_second_state", state4, {16{8'h16}});
      if (i == 11) en_i = 1'b0;
      tick();
    end
    check("coll_done_pattern", done_seq, 16'b0100_0010_0001_0000);
    for (int i = 0; i < 4; i++) tick();

    // Reset two cycles after acceptance discards the block.
    start(APPB_IN, 1'b0);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_state", state4, '0);
    check("midrst_flags", {done4, lr4, busy4}, 3'b000);
    tick();
    rst_n = 1'b1;
    done_seq = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      done_seq[i] = done4;
    end
    check("midrst_no_done", done_seq, '0);
    start({16{8'h53}}, 1'b1);
    wait_done4(lat);
    check("midrst_next_latency", lat, 4);
    check("midrst_next_state", state4, {16{8'hed}});
    check("midrst_next_lr", lr4, 1'b1);
    for (int i = 0; i < 4; i++) tick();

    // Same vector through all three widths.
    start(APPB_IN, 1'b0);
    lat = -1; lat8 = -1; lat16 = -1;
    bsy4 = 0; bsy8 = 0; bsy16 = 0;
    res8 = '0; res16 = '0;
    for (int i = 0; i < 8; i++) begin
      if (busy4) bsy4++;
      if (busy8) bsy8++;
      if (busy16) bsy16++;
      if (done4 && lat < 0) lat = i;
      if (done8 && lat8 < 0) begin lat8 = i; res8 = state8; end
      if (done16 && lat16 < 0) begin lat16 = i; res16 = state16; end
      tick();
    end
    check("sweep4_latency", lat, 4);
    check("sweep8_latency", lat8, 2);
    check("sweep16_latency", lat16, 1);
    check("sweep4_busy", bsy4, 4);
    check("sweep8_busy", bsy8, 2);
    check("sweep16_busy", bsy16, 1);
    check("sweep4_state", state4, APPB_OUT);
    check("sweep8_state", res8, APPB_OUT);
    check("sweep16_state", res16, APPB_OUT);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
